// File: rtl/jtkiwi_shram.sv
// Shared 8-bit RAM for the main CPU and the sound (sub) CPU. Main accesses stall
// on main_busy. Sub writes are posted through a one-entry buffer. Sub reads stall on mshramen.
module jtkiwi_shram #(
    parameter int AW = 13
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          main_cs,
    input  logic          main_rnw,
    input  logic [AW-1:0] main_addr,
    input  logic [7:0]    main_dout,
    output logic [7:0]    main_din,
    output logic          main_busy,
    input  logic          ram_cs,
    input  logic          cpu_rnw,
    input  logic [AW-1:0] ram_addr,
    input  logic [7:0]    ram_din,
    output logic [7:0]    ram_dout,
    output logic          mshramen,
    output logic          wr_ovf
);
    typedef enum logic [1:0] {IDLE, WBUF, MAIN, SUB} state_t;
    typedef enum logic {SIDE_MAIN, SIDE_SUB} side_t;

    state_t          state_q, state_d;
    side_t           last_q, last_d;
    logic            ph_q, ph_d;
    logic            full_q, full_d;
    logic [AW-1:0]   buf_addr_q, buf_addr_d;
    logic [7:0]      buf_data_q, buf_data_d;
    logic            wr_ovf_q, wr_ovf_d;
    logic            wr_seen_q, wr_seen_d;
    logic            main_done_q, main_done_d;
    logic            sub_done_q, sub_done_d;
    logic [7:0]      main_din_q, main_din_d;
    logic [7:0]      ram_dout_q, ram_dout_d;

    logic [7:0]      mem [0:(1<<AW)-1];
    logic [7:0]      ram_q;
    logic            ram_we;
    logic [AW-1:0]   ram_a;
    logic [7:0]      ram_wd;

    logic            sub_strobe, main_pend, sub_pend, main_done_set, sub_done_set;

    // A request that has already strobed a write is never also a read.
    assign sub_strobe = ram_cs & ~cpu_rnw;
    assign main_pend  = main_cs & ~main_done_q;
    assign sub_pend   = ram_cs & cpu_rnw & ~wr_seen_q & ~sub_done_q;

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        ph_d          = ph_q;
        full_d        = full_q;
        buf_addr_d    = buf_addr_q;
        buf_data_d    = buf_data_q;
        wr_ovf_d      = wr_ovf_q;
        main_din_d    = main_din_q;
        ram_dout_d    = ram_dout_q;
        main_done_set = 1'b0;
        sub_done_set  = 1'b0;
        ram_we        = 1'b0;
        ram_a         = main_addr;
        ram_wd        = main_dout;

        if (sub_strobe) begin
            if (full_q) begin
                wr_ovf_d = 1'b1;
            end else begin
                full_d     = 1'b1;
                buf_addr_d = ram_addr;
                buf_data_d = ram_din;
            end
        end

        case (state_q)
            IDLE: begin
                ph_d = 1'b0;
                if (full_q)                    state_d = WBUF;
                else if (main_pend && sub_pend) state_d = (last_q == SIDE_SUB) ? MAIN : SUB;
                else if (main_pend)            state_d = MAIN;
                else if (sub_pend)             state_d = SUB;
            end
            WBUF: begin
                ram_we  = 1'b1;
                ram_a   = buf_addr_q;
                ram_wd  = buf_data_q;
                full_d  = 1'b0;
                state_d = IDLE;
            end
            MAIN: begin
                if (!ph_q) begin
                    if (main_cs) begin
                        ram_we = ~main_rnw;
                        ph_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (main_rnw) main_din_d = ram_q;
                    main_done_set = 1'b1;
                    last_d        = SIDE_MAIN;
                    ph_d          = 1'b0;
                    state_d       = IDLE;
                end
            end
            SUB: begin
                ram_a = ram_addr;
                if (!ph_q) begin
                    if (sub_pend) ph_d = 1'b1;
                    else          state_d = IDLE;
                end else begin
                    ram_dout_d   = ram_q;
                    sub_done_set = 1'b1;
                    last_d       = SIDE_SUB;
                    ph_d         = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        main_done_d = main_cs & (main_done_q | main_done_set);
        sub_done_d  = ram_cs & (sub_done_q | sub_done_set);
        wr_seen_d   = ram_cs & (wr_seen_q | sub_strobe);
    end

    // NOTE: sequential state uses <= so every flop samples the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= SIDE_SUB;
            ph_q        <= 1'b0;
            full_q      <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            wr_ovf_q    <= 1'b0;
            wr_seen_q   <= 1'b0;
            main_done_q <= 1'b0;
            sub_done_q  <= 1'b0;
            main_din_q  <= '0;
            ram_dout_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            ph_q        <= ph_d;
            full_q      <= full_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            wr_ovf_q    <= wr_ovf_d;
            wr_seen_q   <= wr_seen_d;
            main_done_q <= main_done_d;
            sub_done_q  <= sub_done_d;
            main_din_q  <= main_din_d;
            ram_dout_q  <= ram_dout_d;
        end
    end

    // NOTE: the array has no reset. Resetting the FSM forces ram_we low, which aborts an access in flight.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_wd;
        ram_q <= mem[ram_a];
    end

    assign main_din  = main_din_q;
    assign ram_dout  = ram_dout_q;
    assign wr_ovf    = wr_ovf_q;
    assign main_busy = main_cs & ~main_done_q;
    assign mshramen  = ram_cs & (sub_pend | full_q);

endmodule

// File: tb/tb_jtkiwi_shram.sv
// Directed bench for jtkiwi_shram. It checks main/sub access latency, the posted-write
// buffer, the overflow flag, abort on reset, and round-robin alternation.
module tb_jtkiwi_shram;
    localparam int AW = 13;

    logic          rst = 1'b1;
    logic          clk = 1'b0;
    logic          main_cs = 1'b0, main_rnw = 1'b1;
    logic [AW-1:0] main_addr = '0;
    logic [7:0]    main_dout = '0;
    logic [7:0]    main_din;
    logic          main_busy;
    logic          ram_cs = 1'b0, cpu_rnw = 1'b1;
    logic [AW-1:0] ram_addr = '0;
    logic [7:0]    ram_din = '0;
    logic [7:0]    ram_dout;
    logic          mshramen, wr_ovf;

    int checks = 0;
    int errors = 0;

    jtkiwi_shram #(.AW(AW)) dut (
        .rst(rst), .clk(clk),
        .main_cs(main_cs), .main_rnw(main_rnw), .main_addr(main_addr),
        .main_dout(main_dout), .main_din(main_din), .main_busy(main_busy),
        .ram_cs(ram_cs), .cpu_rnw(cpu_rnw), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout), .mshramen(mshramen), .wr_ovf(wr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Counts the clock edges sampled with main_busy high, including the edge that completes the access.
    task automatic main_access(input logic rnw, input logic [AW-1:0] a, input logic [7:0] d,
                               output int cyc);
        main_rnw = rnw; main_addr = a; main_dout = d; main_cs = 1'b1; cyc = 0;
        do begin step; cyc++; end while (main_busy && cyc < 40);
        main_cs = 1'b0;
        step;
    endtask

    task automatic sub_read(input logic [AW-1:0] a, output int cyc);
        ram_addr = a; cpu_rnw = 1'b1; ram_cs = 1'b1; cyc = 0;
        do begin step; cyc++; end while (mshramen && cyc < 40);
        ram_cs = 1'b0;
        step;
    endtask

    task automatic sub_write(input logic [AW-1:0] a, input logic [7:0] d);
        ram_addr = a; ram_din = d; cpu_rnw = 1'b0; ram_cs = 1'b1;
        #1;
        check("sub_wr_no_wait", mshramen, 1'b0);
        @(posedge clk); #1;
        ram_cs = 1'b0; cpu_rnw = 1'b1;
        step;
    endtask

    initial begin
        int c, m_at, s_at, mw, sw, n, last_side, mn;

        // Reset values
        repeat (3) step;
        check("rst_main_din", main_din, 8'h00);
        check("rst_ram_dout", ram_dout, 8'h00);
        check("rst_busy", main_busy, 1'b0);
        check("rst_mshramen", mshramen, 1'b0);
        check("rst_wr_ovf", wr_ovf, 1'b0);
        rst = 1'b0;
        step;

        // Main write then read, uncontended
        main_access(1'b0, 13'h0123, 8'h5A, c);
        check("m_wr_cyc", c, 3);
        main_access(1'b1, 13'h0123, 8'h00, c);
        check("m_rd_cyc", c, 3);
        check("m_rd_data", main_din, 8'h5A);

        // Posted sub write, then a read that waits for the buffer drain (WBUF, SUB x2)
        sub_write(13'h1FFF, 8'hC3);
        sub_read(13'h1FFF, c);
        check("s_rd_cyc", c, 4);
        check("s_rd_data", ram_dout, 8'hC3);
        main_access(1'b1, 13'h1FFF, 8'h00, c);
        check("m_rd_sub_data", main_din, 8'hC3);

        // Simultaneous requests after reset: main first, then IDLE plus a two-clock SUB
        rst = 1'b1; step; rst = 1'b0; step;
        main_addr = 13'h0123; main_rnw = 1'b1; main_cs = 1'b1;
        ram_addr = 13'h1FFF; cpu_rnw = 1'b1; ram_cs = 1'b1;
        m_at = 0; s_at = 0;
        for (int k = 1; k <= 30 && (m_at == 0 || s_at == 0); k++) begin
            step;
            if (main_cs && !main_busy) begin m_at = k; main_cs = 1'b0; end
            if (ram_cs && !mshramen)   begin s_at = k; ram_cs = 1'b0; end
        end
        step;
        check("arb_main_done_at", m_at, 3);
        check("arb_sub_done_at", s_at, 6);
        check("arb_main_data", main_din, 8'h5A);
        check("arb_sub_data", ram_dout, 8'hC3);

        // Two strobes while main holds the RAM: the first is kept, the second is dropped
        main_access(1'b0, 13'h0201, 8'h77, c);
        main_addr = 13'h0123; main_rnw = 1'b1; main_cs = 1'b1;
        ram_addr = 13'h0200; ram_din = 8'h11; cpu_rnw = 1'b0; ram_cs = 1'b1;
        step;
        ram_addr = 13'h0201; ram_din = 8'h22;
        step;
        ram_cs = 1'b0; cpu_rnw = 1'b1;
        check("ovf_set", wr_ovf, 1'b1);
        check("ovf_main_busy", main_busy, 1'b1);
        c = 0;
        while (main_busy && c < 40) begin step; c++; end
        check("ovf_main_wait", c, 1);
        main_cs = 1'b0;
        check("ovf_main_data", main_din, 8'h5A);
        step;
        sub_read(13'h0200, c);
        check("ovf_kept", ram_dout, 8'h11);
        sub_read(13'h0201, c);
        check("ovf_dropped", ram_dout, 8'h77);
        check("ovf_sticky", wr_ovf, 1'b1);

        // Reset during MAIN clock 1 aborts the write
        main_access(1'b0, 13'h0010, 8'h00, c);
        main_addr = 13'h0010; main_rnw = 1'b0; main_dout = 8'hA5; main_cs = 1'b1;
        step;
        rst = 1'b1;
        main_cs = 1'b0;
        #1;
        check("abort_main_din", main_din, 8'h00);
        check("abort_ram_dout", ram_dout, 8'h00);
        check("abort_wr_ovf", wr_ovf, 1'b0);
        check("abort_busy", main_busy, 1'b0);
        check("abort_mshramen", mshramen, 1'b0);
        #2 rst = 1'b0;
        step;
        main_access(1'b1, 13'h0010, 8'h00, c);
        check("abort_rd_cyc", c, 3);
        check("abort_rd_data", main_din, 8'h00);

        // Back-to-back reads on both sides alternate. Each side drops for one clock between requests.
        main_addr = 13'h0123; main_rnw = 1'b1; main_cs = 1'b1;
        ram_addr = 13'h1FFF; cpu_rnw = 1'b1; ram_cs = 1'b0;
        mw = 0; sw = 0; n = 0; mn = 0; last_side = -1;
        for (int k = 0; k < 80 && n < 8; k++) begin
            step;
            if (main_cs) begin
                mw++;
                if (!main_busy) begin
                    check("b2b_m_data", main_din, 8'h5A);
                    check("b2b_m_wait", mw, (mn == 0) ? 3 : 5);
                    if (last_side >= 0) check("b2b_alt_m", last_side, 1);
                    last_side = 0; n++; mn++;
                    main_cs = 1'b0;
                end
            end else begin
                main_cs = 1'b1; mw = 0;
            end
            if (ram_cs) begin
                sw++;
                if (!mshramen) begin
                    check("b2b_s_data", ram_dout, 8'hC3);
                    check("b2b_s_wait", sw, 5);
                    if (last_side >= 0) check("b2b_alt_s", last_side, 0);
                    last_side = 1; n++;
                    ram_cs = 1'b0;
                end
            end else begin
                ram_cs = 1'b1; sw = 0;
            end
        end
        check("b2b_count", n, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
